sm2compl_stream: RTL and testbench

- Streaming converter from sign-magnitude (SM) to two's complement (2C) for message vectors on the VNU path of the DGLDPC decoder.
- Sits between the check-node/message memory (SM domain) and the VNU adders (2C domain).
- Inverse direction of the existing 2C-to-SM conversion.
- Adds a 2-stage pipeline, valid/ready backpressure, frame-beat tracking and negative-zero statistics.

---
 rtl/sm2compl_stream.sv | 138 +++++++++++++
 tb/tb_sm2compl_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm2compl_stream.sv
// rtl/sm2compl_stream.sv - sign-magnitude to two's complement streaming converter
//
// Converts LANES sign-magnitude messages per beat into two's complement,
// through a two-stage valid/ready pipeline. It also counts negative-zero
// lanes and flags frames that run past FRAME_BEATS beats without i_last.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_clr                 clears o_nzero_cnt and o_frame_err
//   i_valid/o_ready       input beat handshake, i_data / i_last payload
//   o_valid/i_ready       output beat handshake, o_data / o_last payload
//   o_nzero_cnt           saturating count of accepted negative-zero lanes
//   o_frame_err           sticky frame-overrun flag
module sm2compl_stream #(
    parameter int W           = 11,
    parameter int LANES       = 4,
    parameter int FRAME_BEATS = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [LANES*W-1:0]   i_data,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [LANES*W-1:0]   o_data,
    output logic                 o_last,
    output logic [CNT_W-1:0]     o_nzero_cnt,
    output logic                 o_frame_err
);

    localparam int DW  = LANES * W;
    localparam int BW  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int NZW = $clog2(LANES + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BEATS - 1);
    localparam logic [W-1:0]  NEG_ZERO = {1'b1, {(W-1){1'b0}}};

    logic            r_s1_valid;
    logic [DW-1:0]   r_s1_data;
    logic            r_s1_last;
    logic            r_s2_valid;
    logic [DW-1:0]   r_s2_data;
    logic            r_s2_last;
    logic [CNT_W-1:0] r_nz_cnt;
    logic [BW-1:0]   r_beat;
    logic            r_frame_err;

    logic            w_s2_load;
    logic            w_ready;
    logic            w_in_xfer;
    logic            w_overrun;
    logic [DW-1:0]   w_conv;
    logic [NZW-1:0]  w_nz_lanes;
    logic [CNT_W:0]  w_nz_sum;
    logic [CNT_W-1:0] w_nz_next;

    // Stage 2 can take a new beat when empty or draining this cycle; stage 1
    // frees up when empty or moving into stage 2.
    assign w_s2_load = !r_s2_valid || i_ready;
    assign w_ready   = !r_s1_valid || w_s2_load;
    assign w_in_xfer = i_valid && w_ready;
    assign w_overrun = w_in_xfer && !i_last && (r_beat == LAST_IDX);

    always_comb begin
        w_conv     = '0;
        w_nz_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            // Negation of {0,m}; negative zero naturally folds to 0.
            if (r_s1_data[k*W+W-1])
                w_conv[k*W +: W] = ~{1'b0, r_s1_data[k*W +: W-1]} + W'(1);
            else
                w_conv[k*W +: W] = {1'b0, r_s1_data[k*W +: W-1]};
            if (i_data[k*W +: W] == NEG_ZERO)
                w_nz_lanes = w_nz_lanes + NZW'(1);
        end
    end

    assign w_nz_sum  = {1'b0, r_nz_cnt} + (CNT_W+1)'(w_nz_lanes);
    assign w_nz_next = w_nz_sum[CNT_W] ? {CNT_W{1'b1}} : w_nz_sum[CNT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_last   <= 1'b0;
            r_nz_cnt    <= '0;
            r_beat      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ready)
                r_s1_valid <= i_valid;
            if (w_in_xfer) begin
                r_s1_data <= i_data;
                r_s1_last <= i_last;
            end

            // Payload only moves with a real beat so a stalled output holds.
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_conv;
                    r_s2_last <= r_s1_last;
                end
            end

            if (i_clr)
                r_nz_cnt <= '0;
            else if (w_in_xfer)
                r_nz_cnt <= w_nz_next;

            if (w_in_xfer) begin
                if (i_last || r_beat == LAST_IDX)
                    r_beat <= '0;
                else
                    r_beat <= r_beat + BW'(1);
            end

            if (i_clr)
                r_frame_err <= 1'b0;
            else if (w_overrun)
                r_frame_err <= 1'b1;
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = r_s2_valid;
    assign o_data      = r_s2_data;
    assign o_last      = r_s2_last;
    assign o_nzero_cnt = r_nz_cnt;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_sm2compl_stream.sv
// tb/tb_sm2compl_stream.sv - self-checking bench for sm2compl_stream
module tb_sm2compl_stream;

    localparam int W     = 11;
    localparam int LANES = 4;
    localparam int FB    = 64;
    localparam int CNT_W = 6;
    localparam int DW    = W * LANES;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_clr = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [DW-1:0]   i_data = '0;
    logic            i_last = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic [CNT_W-1:0] o_nzero_cnt;
    logic            o_frame_err;

    sm2compl_stream #(.W(W), .LANES(LANES), .FRAME_BEATS(FB), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_clr(i_clr),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
        .o_nzero_cnt(o_nzero_cnt), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            m_nz = 0;
    int            m_beat = 0;
    logic          m_ferr = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic          obs_ready;
    logic          last_acc;
    int            n_out = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference conversion: SM value to an integer, then wrap modulo 2^W.
    function automatic logic [DW-1:0] ref_conv(input logic [DW-1:0] x);
        logic [DW-1:0] r = '0;
        for (int k = 0; k < LANES; k++) begin
            int mag = int'(x[k*W +: W-1]);
            int v   = x[k*W+W-1] ? -mag : mag;
            r[k*W +: W] = W'(v);
        end
        return r;
    endfunction

    function automatic int ref_nz(input logic [DW-1:0] x);
        int n = 0;
        for (int k = 0; k < LANES; k++)
            if (x[k*W+W-1] && x[k*W +: W-1] == 0) n++;
        return n;
    endfunction

    // One cycle: check registered outputs, drive inputs, score handshakes.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic rdy, input logic clr);
        @(negedge clk);
        check("nzero_cnt", 64'(o_nzero_cnt), 64'(m_nz));
        check("frame_err", 64'(o_frame_err), 64'(m_ferr));
        if (stall_prev) begin
            check("stall_valid", 64'(o_valid), 64'(1));
            check("stall_data", 64'(o_data), 64'(prev_data));
            check("stall_last", 64'(o_last), 64'(prev_last));
        end
        obs_valid = o_valid;
        obs_data  = o_data;
        i_valid = v; i_data = d; i_last = l; i_ready = rdy; i_clr = clr;
        #1;
        obs_ready = o_ready;
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 64'(1), 64'(0));
            end else begin
                beat_t e = exp_q.pop_front();
                check("out_data", 64'(o_data), 64'(e.d));
                check("out_last", 64'(o_last), 64'(e.l));
            end
            n_out++;
        end
        stall_prev = o_valid && !i_ready;
        prev_data  = o_data;
        prev_last  = o_last;
        last_acc   = i_valid && o_ready;
        if (last_acc) begin
            beat_t b;
            b.d = ref_conv(i_data);
            b.l = i_last;
            exp_q.push_back(b);
        end
        if (i_clr) begin
            m_nz   = 0;
            m_ferr = 1'b0;
        end else if (last_acc) begin
            m_nz = m_nz + ref_nz(i_data);
            if (m_nz > 2**CNT_W - 1) m_nz = 2**CNT_W - 1;
        end
        if (last_acc) begin
            if (i_last) m_beat = 0;
            else if (m_beat == FB - 1) begin
                m_beat = 0;
                if (!i_clr) m_ferr = 1'b1;
            end else m_beat++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1; i_valid = 1'b0; i_clr = 1'b0; i_ready = 1'b1; i_last = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_data", 64'(o_data), 64'(0));
        check("rst_last", 64'(o_last), 64'(0));
        check("rst_nz", 64'(o_nzero_cnt), 64'(0));
        check("rst_ferr", 64'(o_frame_err), 64'(0));
        i_rst = 1'b0;
        #1;
        check("rst_ready", 64'(o_ready), 64'(1));
        exp_q.delete();
        m_nz = 0; m_beat = 0; m_ferr = 1'b0; stall_prev = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r = '0;
        for (int k = 0; k < LANES; k++)
            r[k*W +: W] = ($urandom_range(3) == 0) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
        return r;
    endfunction

    task automatic drain();
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] bp_beats [10];
        int idx;
        logic saw_low;

        do_reset();

        // Single beat, latency and constant conversion
        d = {11'h7FF, 11'h3FF, 11'h405, 11'h005};
        step(1'b1, d, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("lat_cycle1", 64'(obs_valid), 64'(0));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("lat_cycle2", 64'(obs_valid), 64'(1));
        check("single_data", 64'(obs_data), 64'({11'h401, 11'h3FF, 11'h7FB, 11'h005}));
        drain();
        check("single_nz", 64'(o_nzero_cnt), 64'(0));

        // Negative zero: 3 beats of all-NZ lanes, then clear
        d = {LANES{11'h400}};
        for (int i = 0; i < 3; i++) step(1'b1, d, 1'b0, 1'b1, 1'b0);
        drain();
        check("nz_twelve", 64'(o_nzero_cnt), 64'(12));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("nz_cleared", 64'(o_nzero_cnt), 64'(0));

        // Backpressure: 10 beats, downstream stalled 5 cycles mid-stream
        for (int i = 0; i < 10; i++) bp_beats[i] = rand_beat();
        idx = 0; saw_low = 1'b0; n_out = 0;
        for (int c = 0; c < 100 && idx < 10; c++) begin
            step(1'b1, bp_beats[idx], 1'b0, !(c >= 4 && c < 9), 1'b0);
            if (!obs_ready) saw_low = 1'b1;
            if (last_acc) idx++;
        end
        check("bp_all_sent", 64'(idx), 64'(10));
        check("bp_ready_drop", 64'(saw_low), 64'(1));
        drain();
        check("bp_count", 64'(n_out), 64'(10));

        // Frame overrun: no i_last for 65 beats, sticky until clear
        do_reset();
        for (int i = 0; i < 63; i++) step(1'b1, rand_beat(), 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ferr_after63", 64'(o_frame_err), 64'(0));
        for (int i = 0; i < 2; i++) step(1'b1, rand_beat(), 1'b0, 1'b1, 1'b0);
        drain();
        check("ferr_after65", 64'(o_frame_err), 64'(1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ferr_cleared", 64'(o_frame_err), 64'(0));

        // Framed traffic: 8-beat frame then full 64-beat frame
        do_reset();
        n_out = 0;
        for (int i = 0; i < 8; i++) step(1'b1, rand_beat(), i == 7, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, rand_beat(), i == 63, 1'b1, 1'b0);
        drain();
        check("frame64_noerr", 64'(o_frame_err), 64'(0));
        check("frame_count", 64'(n_out), 64'(72));

        // Reset with beats in flight
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check("post_rst_idle", 64'(obs_valid), 64'(0));
        end

        // Randomized traffic
        for (int c = 0; c < 1500; c++)
            step($urandom_range(9) < 7, rand_beat(), $urandom_range(7) == 0,
                 $urandom_range(9) < 7, $urandom_range(59) == 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
